// File: rtl/ntt_core_common_param_pkg.sv
// Shared butterfly-array geometry for the NTT core.
package ntt_core_common_param_pkg;

  localparam int R   = 2;  // butterfly radix
  localparam int PSI = 4;  // butterflies per cycle

endpackage : ntt_core_common_param_pkg

// File: rtl/ntt_core_psi_gather_pkg.sv
// Types, sizes and helpers for the PSI gather (input packer) block.
package ntt_core_psi_gather_pkg;

  import ntt_core_common_param_pkg::*;

  localparam int OP_W          = 64;
  localparam int IN_COEF       = 2;
  localparam int N             = 2048;

  localparam int COEF_PER_WORD = R * PSI;
  localparam int SLOT_NB       = COEF_PER_WORD / IN_COEF;
  localparam int WORD_NB       = N / COEF_PER_WORD;

  localparam int SLOT_W        = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
  localparam int WORD_W        = (WORD_NB > 1) ? $clog2(WORD_NB) : 1;
  localparam int IDX_W         = (COEF_PER_WORD > 1) ? $clog2(COEF_PER_WORD) : 1;

  typedef logic [OP_W-1:0]               coef_t;
  typedef coef_t [COEF_PER_WORD-1:0]     word_t;
  typedef coef_t [IN_COEF-1:0]           beat_t;

  // Reverse the IDX_W-bit coefficient index inside a word.
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int b = 0; b < IDX_W; b++) begin
      r[IDX_W-1-b] = k[b];
    end
    return r;
  endfunction

endpackage : ntt_core_psi_gather_pkg

// File: rtl/ntt_core_gather_out_stage.sv
// One-entry output register for the gather block: holds a packed word plus
// its polynomial framing until the butterfly stage takes it.
module ntt_core_gather_out_stage
  import ntt_core_psi_gather_pkg::*;
(
  input  logic  clk,
  input  logic  s_rst,
  input  logic  push_i,   // only asserted when the entry is empty or draining
  input  word_t data_i,
  input  logic  sob_i,
  input  logic  eob_i,
  input  logic  rdy_i,
  output logic  vld_o,
  output word_t data_o,
  output logic  sob_o,
  output logic  eob_o
);

  logic  vld_q;
  word_t data_q;
  logic  sob_q;
  logic  eob_q;

  // Load on push, empty on drain, otherwise hold the word stable.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sob_q  <= 1'b0;
      eob_q  <= 1'b0;
    end else if (push_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      sob_q  <= sob_i;
      eob_q  <= eob_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign sob_o  = sob_q;
  assign eob_o  = eob_q;

endmodule : ntt_core_gather_out_stage

// File: rtl/ntt_core_psi_gather.sv
// Input packer ahead of the PSI radix-R butterflies: gathers IN_COEF-wide
// beats into R*PSI-coefficient words, tracks sob/eob framing, flags framing
// errors and resynchronises on an unexpected sob.
// Build option: NTT_CORE_GATHER_BITREV_EN places in-word coef k at output
// position bitrev(k) (DIT first-stage order); otherwise natural order.
module ntt_core_psi_gather
  import ntt_core_psi_gather_pkg::*;
(
  input  logic                          clk,
  input  logic                          s_rst,
  input  logic [IN_COEF*OP_W-1:0]       in_data,
  input  logic                          in_sob,
  input  logic                          in_eob,
  input  logic                          in_vld,
  output logic                          in_rdy,
  output logic [COEF_PER_WORD*OP_W-1:0] out_data,
  output logic                          out_sob,
  output logic                          out_eob,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          error
);

  function automatic logic [IDX_W-1:0] out_pos(input logic [IDX_W-1:0] k);
`ifdef NTT_CORE_GATHER_BITREV_EN
    return bitrev(k);
`else
    return k;
`endif
  endfunction

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] word_q, word_d;
  word_t             pack_q, pack_d;
  logic              pack_full_q, pack_full_d;
  logic              pack_sob_q, pack_sob_d;
  logic              pack_eob_q, pack_eob_d;
  logic              error_q, error_d;

  beat_t             beat;
  word_t             asm_word;
  word_t             push_data;
  word_t             out_word;
  logic [SLOT_W-1:0] eff_slot;
  logic [WORD_W-1:0] eff_word;
  logic              accept, resync, complete, out_free;
  logic              push_pack, push_new, hold_new, push;
  logic              push_sob, push_eob, new_sob, new_eob;
  logic              sob_exp, eob_exp;

  assign beat   = in_data;
  assign in_rdy = !(pack_full_q && out_vld && !out_rdy);

  // Pack-stage datapath, counters, framing check and hand-off to the out stage.
  always_comb begin
    accept   = in_vld && in_rdy;
    sob_exp  = (slot_q == '0) && (word_q == '0);
    eob_exp  = (slot_q == SLOT_W'(SLOT_NB-1)) && (word_q == WORD_W'(WORD_NB-1));
    // An sob that arrives mid-polynomial restarts packing with this beat.
    resync   = in_sob && !sob_exp;
    eff_slot = resync ? '0 : slot_q;
    eff_word = resync ? '0 : word_q;

    asm_word = pack_q;
    for (int j = 0; j < IN_COEF; j++) begin
      asm_word[out_pos(IDX_W'(int'(eff_slot) * IN_COEF + j))] = beat[j];
    end

    complete  = accept && (eff_slot == SLOT_W'(SLOT_NB-1));
    new_sob   = (eff_word == '0);
    new_eob   = (eff_word == WORD_W'(WORD_NB-1));
    out_free  = !out_vld || out_rdy;
    // A held word always goes out before a freshly completed one.
    push_pack = pack_full_q && out_free;
    push_new  = complete && out_free && !pack_full_q;
    hold_new  = complete && !push_new;
    push      = push_pack || push_new;
    push_data = push_pack ? pack_q     : asm_word;
    push_sob  = push_pack ? pack_sob_q : new_sob;
    push_eob  = push_pack ? pack_eob_q : new_eob;

    slot_d      = slot_q;
    word_d      = word_q;
    pack_d      = pack_q;
    pack_full_d = pack_full_q;
    pack_sob_d  = pack_sob_q;
    pack_eob_d  = pack_eob_q;
    error_d     = error_q;

    if (push_pack) begin
      pack_full_d = 1'b0;
    end

    if (accept) begin
      pack_d = asm_word;
      if ((in_sob != sob_exp) || (in_eob != eob_exp)) begin
        error_d = 1'b1;
      end
      if (eff_slot == SLOT_W'(SLOT_NB-1)) begin
        slot_d = '0;
        word_d = (eff_word == WORD_W'(WORD_NB-1)) ? '0 : eff_word + WORD_W'(1);
      end else begin
        slot_d = eff_slot + SLOT_W'(1);
        word_d = eff_word;
      end
    end

    if (hold_new) begin
      pack_full_d = 1'b1;
      pack_sob_d  = new_sob;
      pack_eob_d  = new_eob;
    end
  end

  // Pack-stage and control registers.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      slot_q      <= '0;
      word_q      <= '0;
      pack_q      <= '0;
      pack_full_q <= 1'b0;
      pack_sob_q  <= 1'b0;
      pack_eob_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      word_q      <= word_d;
      pack_q      <= pack_d;
      pack_full_q <= pack_full_d;
      pack_sob_q  <= pack_sob_d;
      pack_eob_q  <= pack_eob_d;
      error_q     <= error_d;
    end
  end

  ntt_core_gather_out_stage u_out_stage (
    .clk    (clk),
    .s_rst  (s_rst),
    .push_i (push),
    .data_i (push_data),
    .sob_i  (push_sob),
    .eob_i  (push_eob),
    .rdy_i  (out_rdy),
    .vld_o  (out_vld),
    .data_o (out_word),
    .sob_o  (out_sob),
    .eob_o  (out_eob)
  );

  assign out_data = out_word;
  assign error    = error_q;

endmodule : ntt_core_psi_gather

// File: tb/tb_ntt_core_psi_gather.sv
// Scoreboard bench for ntt_core_psi_gather (S=4 slots, W=256 words).
module tb_ntt_core_psi_gather;

  localparam int S     = 4;
  localparam int W     = 256;
  localparam int BEATS = 1024;

  logic         clk = 1'b0;
  logic         s_rst;
  logic [127:0] in_data;
  logic         in_sob, in_eob, in_vld, in_rdy;
  logic [511:0] out_data;
  logic         out_sob, out_eob, out_vld, out_rdy, error;

  always #5 clk = ~clk;

  ntt_core_psi_gather dut (
    .clk      (clk),
    .s_rst    (s_rst),
    .in_data  (in_data),
    .in_sob   (in_sob),
    .in_eob   (in_eob),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_sob  (out_sob),
    .out_eob  (out_eob),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .error    (error)
  );

  typedef struct packed {
    logic [511:0] d;
    logic         sob;
    logic         eob;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_pop;
  int           vec_cnt = 0;
  int           err_cnt = 0;
  int           m_slot, m_word;
  logic         m_err;
  logic [63:0]  m_pack [8];
  int           rdy_mode = 0;
  bit           mon_en = 1'b0;
  int           words_seen, sob_seen, eob_seen;
  logic [511:0] first_data;
  logic         prev_stall;
  logic [513:0] prev_val;

  function automatic int tb_pos(input int k);
`ifdef NTT_CORE_GATHER_BITREV_EN
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] mk(input longint base, input int i);
    logic [127:0] d;
    d[63:0]   = 64'(base + longint'(2 * i));
    d[127:64] = 64'(base + longint'(2 * i + 1));
    return d;
  endfunction

  // out_rdy pattern generator
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'b0;
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output monitor: scoreboard pop and stall-hold check
  initial begin
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (s_rst || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          vec_cnt++;
          if (!out_vld || ({out_data, out_sob, out_eob} !== prev_val)) begin
            err_cnt++;
            $display("FAIL stall_hold: got vld=%0b word=%h, required vld=1 word=%h",
                     out_vld, {out_data, out_sob, out_eob}, prev_val);
          end
        end
        if (out_vld && out_rdy) begin
          vec_cnt++;
          if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL out_word: got unexpected word %h, required none", out_data);
          end else begin
            e_pop = exp_q.pop_front();
            if ({out_data, out_sob, out_eob} !== {e_pop.d, e_pop.sob, e_pop.eob}) begin
              err_cnt++;
              $display("FAIL out_word: got data=%h sob=%0b eob=%0b, required data=%h sob=%0b eob=%0b",
                       out_data, out_sob, out_eob, e_pop.d, e_pop.sob, e_pop.eob);
            end
          end
          if (words_seen == 0) first_data = out_data;
          words_seen++;
          sob_seen += int'(out_sob);
          eob_seen += int'(out_eob);
        end
        prev_stall = out_vld && !out_rdy;
        prev_val   = {out_data, out_sob, out_eob};
      end
    end
  end

  task automatic model_clear();
    m_slot = 0;
    m_word = 0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  task automatic count_clear();
    words_seen = 0;
    sob_seen   = 0;
    eob_seen   = 0;
  endtask

  task automatic model_accept(input logic [127:0] d, input logic sob, input logic eob);
    logic         at_start;
    logic [511:0] w;
    exp_t         e;
    at_start = (m_slot == 0) && (m_word == 0);
    if ((sob != at_start) || (eob != ((m_slot == S-1) && (m_word == W-1)))) m_err = 1'b1;
    if (sob && !at_start) begin
      m_slot = 0;
      m_word = 0;
    end
    m_pack[m_slot*2]   = d[63:0];
    m_pack[m_slot*2+1] = d[127:64];
    if (m_slot == S-1) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[tb_pos(k)*64 +: 64] = m_pack[k];
      e.d   = w;
      e.sob = (m_word == 0);
      e.eob = (m_word == W-1);
      exp_q.push_back(e);
      m_slot = 0;
      m_word = (m_word + 1) % W;
    end else begin
      m_slot++;
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input logic sob, input logic eob);
    bit got = 1'b0;
    in_data = d;
    in_sob  = sob;
    in_eob  = eob;
    in_vld  = 1'b1;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      if (in_rdy) begin
        got = 1'b1;
        model_accept(d, sob, eob);
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: got in_rdy=0 for 500 cycles, required acceptance");
    end
  endtask

  task automatic send_range(input longint base, input int first, input int last, input int bad_eob);
    for (int i = first; i <= last; i++) begin
      send_beat(mk(base, i), (i == 0), (i == BEATS-1) || (i == bad_eob));
    end
  endtask

  task automatic drain();
    in_vld = 1'b0;
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    in_sob = 1'b0;
    in_eob = 1'b0;
    s_rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    count_clear();
    s_rst  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (out_vld !== 1'b0) begin err_cnt++; $display("FAIL reset_out_vld: got %b, required 0", out_vld); end
    vec_cnt++;
    if ({out_sob, out_eob} !== 2'b00) begin err_cnt++; $display("FAIL reset_sob_eob: got %b, required 00", {out_sob, out_eob}); end
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL reset_error: got %b, required 0", error); end
    vec_cnt++;
    if (out_data !== 512'd0) begin err_cnt++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    vec_cnt++;
    if (in_rdy !== 1'b1) begin err_cnt++; $display("FAIL reset_in_rdy: got %b, required 1", in_rdy); end
  endtask

  task automatic test_stream();
    int           ord [8];
    logic [511:0] w0;
`ifdef NTT_CORE_GATHER_BITREV_EN
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int p = 0; p < 8; p++) w0[p*64 +: 64] = 64'(ord[p]);
    count_clear();
    rdy_mode = 0;
    send_range(0, 0, BEATS-1, -1);
    drain();
    vec_cnt++;
    if (words_seen != W) begin err_cnt++; $display("FAIL stream_words: got %0d, required %0d", words_seen, W); end
    vec_cnt++;
    if (sob_seen != 1 || eob_seen != 1) begin err_cnt++; $display("FAIL stream_framing: got sob=%0d eob=%0d, required 1 1", sob_seen, eob_seen); end
    vec_cnt++;
    if (first_data !== w0) begin err_cnt++; $display("FAIL stream_word0: got %h, required %h", first_data, w0); end
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL stream_error: got %b, required 0", error); end
  endtask

  task automatic test_stall();
    int idx = 40;
    int acc = 0;
    send_range(10000, 0, 39, -1);
    drain();
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 12; c++) begin
      in_data = mk(10000, idx);
      in_sob  = 1'b0;
      in_eob  = 1'b0;
      in_vld  = 1'b1;
      @(negedge clk);
      if (in_rdy) begin
        model_accept(mk(10000, idx), 1'b0, 1'b0);
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    vec_cnt++;
    if (acc != 8) begin err_cnt++; $display("FAIL stall_accepted: got %0d beats, required 8", acc); end
    vec_cnt++;
    if (in_rdy !== 1'b0) begin err_cnt++; $display("FAIL stall_in_rdy: got %b, required 0", in_rdy); end
    rdy_mode = 0;
    send_range(10000, idx, BEATS-1, -1);
    drain();
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL stall_error: got %b, required 0", error); end
  endtask

  task automatic test_random();
    count_clear();
    rdy_mode = 2;
    for (int p = 0; p < 4; p++) send_range(longint'(20000 + p * 4096), 0, BEATS-1, -1);
    rdy_mode = 0;
    drain();
    vec_cnt++;
    if (words_seen != 4 * W) begin err_cnt++; $display("FAIL random_words: got %0d, required %0d", words_seen, 4 * W); end
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL random_error: got %b, required 0", error); end
  endtask

  task automatic test_resync();
    do_reset();
    send_range(50000, 0, 41, -1);
    send_range(60000, 0, BEATS-1, -1);
    drain();
    vec_cnt++;
    if (error !== 1'b1) begin err_cnt++; $display("FAIL resync_error: got %b, required 1", error); end
    vec_cnt++;
    if (words_seen != 10 + W || sob_seen != 2) begin
      err_cnt++;
      $display("FAIL resync_words: got words=%0d sob=%0d, required %0d 2", words_seen, sob_seen, 10 + W);
    end
  endtask

  task automatic test_bad_eob();
    do_reset();
    send_range(70000, 0, 403, 403);
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (error !== 1'b1) begin err_cnt++; $display("FAIL eob_error_set: got %b, required 1", error); end
    send_range(70000, 404, BEATS-1, -1);
    drain();
    vec_cnt++;
    if (error !== 1'b1) begin err_cnt++; $display("FAIL eob_error_sticky: got %b, required 1", error); end
    vec_cnt++;
    if (words_seen != W) begin err_cnt++; $display("FAIL eob_words: got %0d, required %0d", words_seen, W); end
  endtask

  task automatic test_srst_mid();
    do_reset();
    send_range(80000, 0, 195, -1);
    drain();
    rdy_mode = 1;
    send_range(80000, 196, 200, -1);
    vec_cnt++;
    if (out_vld !== 1'b1) begin err_cnt++; $display("FAIL srst_pre_vld: got %b, required 1", out_vld); end
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (out_vld !== 1'b0) begin err_cnt++; $display("FAIL srst_out_vld: got %b, required 0", out_vld); end
    vec_cnt++;
    if (in_rdy !== 1'b1) begin err_cnt++; $display("FAIL srst_in_rdy: got %b, required 1", in_rdy); end
    model_clear();
    count_clear();
    in_vld   = 1'b0;
    s_rst    = 1'b0;
    rdy_mode = 0;
    send_range(90000, 0, BEATS-1, -1);
    drain();
    vec_cnt++;
    if (words_seen != W || sob_seen != 1 || eob_seen != 1) begin
      err_cnt++;
      $display("FAIL srst_repack: got words=%0d sob=%0d eob=%0d, required %0d 1 1", words_seen, sob_seen, eob_seen, W);
    end
    vec_cnt++;
    if (error !== 1'b0) begin err_cnt++; $display("FAIL srst_error: got %b, required 0", error); end
  endtask

  initial begin
    s_rst   = 1'b1;
    in_vld  = 1'b0;
    in_sob  = 1'b0;
    in_eob  = 1'b0;
    in_data = '0;
    model_clear();
    count_clear();
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_resync();
    test_bad_eob();
    test_srst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ntt_core_psi_gather
